// File: rtl/xoodyak_op_sequencer.sv
// Host-side command sequencer for xoodyak_build: walks init -> nonce -> assoc -> text blocks -> squeeze,
// pacing the core with start/finished and guarding each wait with a timeout.
module xoodyak_op_sequencer #(
   parameter int NBLK_W      = 8,
   parameter int TIMEOUT_CYC = 64
) (
   input  logic              eph1,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_decrypt,
   input  logic [127:0]      req_key,
   input  logic [127:0]      req_nonce,
   input  logic [351:0]      req_ad,
   input  logic [NBLK_W-1:0] req_nblocks,
   input  logic              blk_valid,
   output logic              blk_ready,
   input  logic [191:0]      blk_data,
   input  logic              abort,
   output logic              core_start,
   output logic [3:0]        core_opmode,
   output logic [191:0]      core_textin,
   output logic [127:0]      core_key,
   output logic [127:0]      core_nonce,
   output logic [351:0]      core_assodata,
   input  logic              core_finished,
   output logic              busy,
   output logic              done,
   output logic              err
);

   localparam int TCNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [TCNT_W-1:0] TCNT_MAX = TCNT_W'(TIMEOUT_CYC - 1);

   typedef enum logic [3:0] {
      IDLE, INIT_ISS, INIT_WAIT, NON_ISS, NON_WAIT, AD_ISS, AD_WAIT,
      TXT_WAITBLK, TXT_ISS, TXT_WAIT, SQZ_ISS, SQZ_WAIT, DONE
   } state_t;

   state_t            state;
   logic              decrypt;
   logic [NBLK_W-1:0] nblocks;
   logic [NBLK_W-1:0] blk_idx;
   logic [TCNT_W-1:0] tcnt;
   logic [NBLK_W-1:0] blk_next;

   assign blk_next  = blk_idx + NBLK_W'(1);
   assign req_ready = (state == IDLE);
   assign blk_ready = (state == TXT_WAITBLK);

   always_ff @(posedge eph1 or negedge reset) begin
      if (!reset) begin
         state         <= IDLE;
         decrypt       <= 1'b0;
         nblocks       <= '0;
         blk_idx       <= '0;
         tcnt          <= '0;
         core_start    <= 1'b0;
         core_opmode   <= 4'h0;
         core_textin   <= '0;
         core_key      <= '0;
         core_nonce    <= '0;
         core_assodata <= '0;
         busy          <= 1'b0;
         done          <= 1'b0;
         err           <= 1'b0;
      end else begin
         core_start <= 1'b0;
         done       <= 1'b0;
         if (abort && state != IDLE) begin
            state       <= IDLE;
            busy        <= 1'b0;
            core_opmode <= 4'h0;
         end else begin
            case (state)
               IDLE: begin
                  if (req_valid) begin
                     core_key      <= req_key;
                     core_nonce    <= req_nonce;
                     core_assodata <= req_ad;
                     decrypt       <= req_decrypt;
                     nblocks       <= req_nblocks;
                     blk_idx       <= '0;
                     err           <= 1'b0;
                     busy          <= 1'b1;
                     core_start    <= 1'b1;
                     core_opmode   <= 4'h1;
                     state         <= INIT_ISS;
                  end
               end
               // Each issue cycle only restarts the watchdog; finished here belongs to no op yet.
               INIT_ISS: begin tcnt <= '0; state <= INIT_WAIT; end
               NON_ISS:  begin tcnt <= '0; state <= NON_WAIT;  end
               AD_ISS:   begin tcnt <= '0; state <= AD_WAIT;   end
               TXT_ISS:  begin tcnt <= '0; state <= TXT_WAIT;  end
               SQZ_ISS:  begin tcnt <= '0; state <= SQZ_WAIT;  end
               TXT_WAITBLK: begin
                  if (blk_valid) begin
                     core_textin <= blk_data;
                     core_start  <= 1'b1;
                     core_opmode <= {blk_idx != '0, decrypt ? 3'd5 : 3'd4};
                     state       <= TXT_ISS;
                  end
               end
               DONE: begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end
               default: begin
                  if (core_finished) begin
                     case (state)
                        INIT_WAIT: begin
                           core_start  <= 1'b1;
                           core_opmode <= 4'h2;
                           state       <= NON_ISS;
                        end
                        NON_WAIT: begin
                           core_start  <= 1'b1;
                           core_opmode <= 4'h3;
                           state       <= AD_ISS;
                        end
                        AD_WAIT: begin
                           if (nblocks == '0) begin
                              core_start  <= 1'b1;
                              core_opmode <= 4'h6;
                              state       <= SQZ_ISS;
                           end else begin
                              core_opmode <= 4'h0;
                              state       <= TXT_WAITBLK;
                           end
                        end
                        TXT_WAIT: begin
                           blk_idx <= blk_next;
                           if (blk_next == nblocks) begin
                              core_start  <= 1'b1;
                              core_opmode <= 4'h6;
                              state       <= SQZ_ISS;
                           end else begin
                              core_opmode <= 4'h0;
                              state       <= TXT_WAITBLK;
                           end
                        end
                        SQZ_WAIT: begin
                           done        <= 1'b1;
                           core_opmode <= 4'h0;
                           state       <= DONE;
                        end
                        default: begin
                           busy        <= 1'b0;
                           core_opmode <= 4'h0;
                           state       <= IDLE;
                        end
                     endcase
                  end else if (tcnt == TCNT_MAX) begin
                     err         <= 1'b1;
                     busy        <= 1'b0;
                     core_opmode <= 4'h0;
                     state       <= IDLE;
                  end else begin
                     tcnt <= tcnt + TCNT_W'(1);
                  end
               end
            endcase
         end
      end
   end

endmodule
